// File: rtl/pa_clint_busif.sv
// AHB-Lite slave front end of the CLINT: address decode, data-phase strobes, read mux, OKAY/ERROR responses.
// Optional macro CLINT_ERR_RESP_EN enables the two-cycle ERROR response; otherwise illegal transfers complete OKAY.
module pa_clint_busif #(
  parameter int ADDR_W = 16
) (
  input  logic              clint_clk,
  input  logic              cpurst_b,
  input  logic              clint_hsel,
  input  logic [1:0]        clint_htrans,
  input  logic              clint_hwrite,
  input  logic [ADDR_W-1:0] clint_haddr,
  input  logic [2:0]        clint_hsize,
  input  logic [31:0]       clint_hwdata,
  output logic              clint_hready,
  output logic              clint_hresp,
  output logic [31:0]       clint_hrdata,
  input  logic [1:0]        cpu_clint_mode,
  output logic              busif_regs_msip_sel,
  output logic              busif_regs_mtimecmp_lo_sel,
  output logic              busif_regs_mtimecmp_hi_sel,
  output logic [31:0]       busif_regs_wdata,
  output logic              busif_regs_write_vld,
  input  logic [31:0]       msip_value,
  input  logic [31:0]       mtimecmp_lo_value,
  input  logic [31:0]       mtimecmp_hi_value,
  input  logic [31:0]       mtime_lo_value,
  input  logic [31:0]       mtime_hi_value
);

`ifdef CLINT_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int NREG = 5;
  // Index order: 0 MSIP, 1 MTIMECMP_LO, 2 MTIMECMP_HI, 3 MTIME_LO, 4 MTIME_HI
  localparam logic [NREG-1:0][ADDR_W-1:0] REG_ADDR = {
    ADDR_W'(16'hBFFC), ADDR_W'(16'hBFF8), ADDR_W'(16'h4004),
    ADDR_W'(16'h4000), ADDR_W'(16'h0000)
  };

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t              state_reg, state_next;
  logic                write_reg;
  logic [NREG-1:0]     sel_reg;
  logic                illegal_reg;

  logic                accept;
  logic [NREG-1:0]     sel_dec;
  logic                illegal_dec;
  logic [NREG-1:0][31:0] reg_value;
  logic [31:0]         rd_mux;
  logic                data_ok;

  assign reg_value = {mtime_hi_value, mtime_lo_value, mtimecmp_hi_value,
                      mtimecmp_lo_value, msip_value};

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_dec
      assign sel_dec[gi] = (clint_haddr == REG_ADDR[gi]);
    end
  endgenerate

  assign accept = clint_hsel & clint_htrans[1] & clint_hready;

  // MTIME words are read-only; any write requires machine mode
  assign illegal_dec = (clint_hsize != 3'b010)
                     | (clint_haddr[1:0] != 2'b00)
                     | ~(|sel_dec)
                     | (clint_hwrite & (sel_dec[3] | sel_dec[4]))
                     | (clint_hwrite & (cpu_clint_mode != 2'b11));

  always_ff @(posedge clint_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg   <= IDLE;
      write_reg   <= 1'b0;
      sel_reg     <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        write_reg   <= clint_hwrite;
        sel_reg     <= sel_dec;
        illegal_reg <= illegal_dec;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NREG; i++) begin
      rd_mux = rd_mux | ({32{sel_reg[i]}} & reg_value[i]);
    end
  end

  always_comb begin
    state_next                 = IDLE;
    clint_hready               = 1'b1;
    clint_hresp                = 1'b0;
    clint_hrdata               = '0;
    busif_regs_write_vld       = 1'b0;
    busif_regs_msip_sel        = 1'b0;
    busif_regs_mtimecmp_lo_sel = 1'b0;
    busif_regs_mtimecmp_hi_sel = 1'b0;
    data_ok                    = (state_reg == DATA) & ~illegal_reg;

    case (state_reg)
      ERR1:    state_next = ERR2;
      default: if (accept) state_next = (ERR_EN && illegal_dec) ? ERR1 : DATA;
    endcase

    clint_hready = (state_reg != ERR1);
`ifdef CLINT_ERR_RESP_EN
    clint_hresp  = (state_reg == ERR1) | (state_reg == ERR2);
`endif

    busif_regs_write_vld       = data_ok & write_reg;
    busif_regs_msip_sel        = busif_regs_write_vld & sel_reg[0];
    busif_regs_mtimecmp_lo_sel = busif_regs_write_vld & sel_reg[1];
    busif_regs_mtimecmp_hi_sel = busif_regs_write_vld & sel_reg[2];
    if (data_ok & ~write_reg) clint_hrdata = rd_mux;
  end

  assign busif_regs_wdata = clint_hwdata;

endmodule

// File: tb/tb_pa_clint_busif.sv
// Directed self-checking bench for pa_clint_busif; follows CLINT_ERR_RESP_EN when defined.
module tb_pa_clint_busif;
  logic        clint_clk = 1'b0;
  logic        cpurst_b = 1'b1;
  logic        clint_hsel, clint_hwrite;
  logic [1:0]  clint_htrans, cpu_clint_mode;
  logic [15:0] clint_haddr;
  logic [2:0]  clint_hsize;
  logic [31:0] clint_hwdata;
  logic        clint_hready, clint_hresp;
  logic [31:0] clint_hrdata;
  logic        busif_regs_msip_sel, busif_regs_mtimecmp_lo_sel, busif_regs_mtimecmp_hi_sel;
  logic [31:0] busif_regs_wdata;
  logic        busif_regs_write_vld;
  logic [31:0] msip_value, mtimecmp_lo_value, mtimecmp_hi_value, mtime_lo_value, mtime_hi_value;
  logic [5:0]  ctl;
  int          total = 0;
  int          bad = 0;

  always #5 clint_clk = ~clint_clk;

  // {hready, hresp, msip_sel, mtimecmp_lo_sel, mtimecmp_hi_sel, write_vld}
  assign ctl = {clint_hready, clint_hresp, busif_regs_msip_sel, busif_regs_mtimecmp_lo_sel,
                busif_regs_mtimecmp_hi_sel, busif_regs_write_vld};

  pa_clint_busif #(.ADDR_W(16)) dut (
    .clint_clk(clint_clk), .cpurst_b(cpurst_b), .clint_hsel(clint_hsel),
    .clint_htrans(clint_htrans), .clint_hwrite(clint_hwrite), .clint_haddr(clint_haddr),
    .clint_hsize(clint_hsize), .clint_hwdata(clint_hwdata), .clint_hready(clint_hready),
    .clint_hresp(clint_hresp), .clint_hrdata(clint_hrdata), .cpu_clint_mode(cpu_clint_mode),
    .busif_regs_msip_sel(busif_regs_msip_sel),
    .busif_regs_mtimecmp_lo_sel(busif_regs_mtimecmp_lo_sel),
    .busif_regs_mtimecmp_hi_sel(busif_regs_mtimecmp_hi_sel),
    .busif_regs_wdata(busif_regs_wdata), .busif_regs_write_vld(busif_regs_write_vld),
    .msip_value(msip_value), .mtimecmp_lo_value(mtimecmp_lo_value),
    .mtimecmp_hi_value(mtimecmp_hi_value), .mtime_lo_value(mtime_lo_value),
    .mtime_hi_value(mtime_hi_value)
  );

  task tick();
    @(posedge clint_clk);
    #1;
  endtask

  task addr_phase(input logic wr, input logic [15:0] a, input logic [2:0] sz, input logic [1:0] md);
    clint_hsel = 1'b1; clint_htrans = 2'b10; clint_hwrite = wr;
    clint_haddr = a; clint_hsize = sz; cpu_clint_mode = md;
  endtask

  task idle_bus();
    clint_hsel = 1'b0; clint_htrans = 2'b00; clint_hwrite = 1'b0;
    clint_haddr = 16'h0; clint_hsize = 3'b010; cpu_clint_mode = 2'b11;
  endtask

  task test_reset();
    idle_bus();
    clint_hwdata = 32'h0;
    #2 cpurst_b = 1'b0;
    addr_phase(1'b1, 16'h0000, 3'b010, 2'b11);
    clint_hwdata = 32'h1;
    tick(); tick(); #1;
    $display("txn reset hold ctl=%b hrdata=%h", ctl, clint_hrdata);
    if (ctl !== 6'b100000) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, 6'b100000); end
    total++;
    if (clint_hrdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h want=%h", clint_hrdata, 32'h0); end
    total++;
    idle_bus();
    cpurst_b = 1'b1;
  endtask

  task test_idle_htrans();
    clint_hsel = 1'b1; clint_htrans = 2'b01; clint_hwrite = 1'b1;
    clint_haddr = 16'h0000; clint_hsize = 3'b010; cpu_clint_mode = 2'b11;
    tick();
    clint_hsel = 1'b0; clint_htrans = 2'b10;
    #1;
    $display("txn busy-htrans write ctl=%b", ctl);
    if (ctl !== 6'b100000) begin bad++; $display("FAIL busy_ctl got=%b want=%b", ctl, 6'b100000); end
    total++;
    tick(); idle_bus(); #1;
    $display("txn hsel=0 write ctl=%b", ctl);
    if (ctl !== 6'b100000) begin bad++; $display("FAIL nosel_ctl got=%b want=%b", ctl, 6'b100000); end
    total++;
  endtask

  task test_write_msip();
    addr_phase(1'b1, 16'h0000, 3'b010, 2'b11);
    tick(); idle_bus(); clint_hwdata = 32'h1; #1;
    $display("txn write 0x0000 ctl=%b wdata=%h", ctl, busif_regs_wdata);
    if (ctl !== 6'b101001) begin bad++; $display("FAIL wr_msip_ctl got=%b want=%b", ctl, 6'b101001); end
    total++;
    if (busif_regs_wdata !== 32'h1) begin bad++; $display("FAIL wr_msip_wdata got=%h want=%h", busif_regs_wdata, 32'h1); end
    total++;
    tick(); #1;
    if (ctl !== 6'b100000) begin bad++; $display("FAIL wr_msip_after got=%b want=%b", ctl, 6'b100000); end
    total++;
  endtask

  task test_read_cmp_hi();
    mtimecmp_hi_value = 32'hFFFF_FFFF;
    addr_phase(1'b0, 16'h4004, 3'b010, 2'b00);
    tick(); idle_bus(); #1;
    $display("txn read 0x4004 ctl=%b hrdata=%h", ctl, clint_hrdata);
    if (ctl !== 6'b100000) begin bad++; $display("FAIL rd_hi_ctl got=%b want=%b", ctl, 6'b100000); end
    total++;
    if (clint_hrdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rd_hi_data got=%h want=%h", clint_hrdata, 32'hFFFF_FFFF); end
    total++;
  endtask

  task test_back_to_back();
    addr_phase(1'b1, 16'h4000, 3'b010, 2'b11);
    tick();
    clint_hwdata = 32'h10;
    addr_phase(1'b0, 16'hBFF8, 3'b010, 2'b11);
    #1;
    $display("txn b2b write 0x4000 ctl=%b wdata=%h", ctl, busif_regs_wdata);
    if (ctl !== 6'b100101) begin bad++; $display("FAIL b2b_wr_lo_ctl got=%b want=%b", ctl, 6'b100101); end
    total++;
    if (busif_regs_wdata !== 32'h10) begin bad++; $display("FAIL b2b_wr_lo_wdata got=%h want=%h", busif_regs_wdata, 32'h10); end
    total++;
    tick();
    clint_hwdata = 32'h0000_AAAA;
    addr_phase(1'b1, 16'h4004, 3'b010, 2'b11);
    #1;
    $display("txn b2b read 0xBFF8 ctl=%b hrdata=%h", ctl, clint_hrdata);
    if (ctl !== 6'b100000) begin bad++; $display("FAIL b2b_rd_ctl got=%b want=%b", ctl, 6'b100000); end
    total++;
    if (clint_hrdata !== 32'h1234) begin bad++; $display("FAIL b2b_rd_data got=%h want=%h", clint_hrdata, 32'h1234); end
    total++;
    tick();
    clint_hwdata = 32'h0;
    idle_bus();
    #1;
    $display("txn b2b write 0x4004 ctl=%b wdata=%h", ctl, busif_regs_wdata);
    if (ctl !== 6'b100011) begin bad++; $display("FAIL b2b_wr_hi_ctl got=%b want=%b", ctl, 6'b100011); end
    total++;
    tick(); #1;
    if (ctl !== 6'b100000 || clint_hrdata !== 32'h0) begin
      bad++; $display("FAIL b2b_idle got=%b/%h want=%b/%h", ctl, clint_hrdata, 6'b100000, 32'h0);
    end
    total++;
  endtask

  // Drives one illegal transfer, then presents a legal read of 0x4000 in the last response cycle.
  task automatic illegal_txn(input string name, input logic wr, input logic [15:0] a,
                             input logic [2:0] sz, input logic [1:0] md);
    addr_phase(wr, a, sz, md);
    tick(); idle_bus(); clint_hwdata = 32'hFFFF_FFFF; #1;
    $display("txn illegal %s ctl=%b hrdata=%h", name, ctl, clint_hrdata);
`ifdef CLINT_ERR_RESP_EN
    if (ctl !== 6'b010000) begin bad++; $display("FAIL %s_err1 got=%b want=%b", name, ctl, 6'b010000); end
    total++;
    if (clint_hrdata !== 32'h0) begin bad++; $display("FAIL %s_err1_data got=%h want=%h", name, clint_hrdata, 32'h0); end
    total++;
    tick(); #1;
    if (ctl !== 6'b110000) begin bad++; $display("FAIL %s_err2 got=%b want=%b", name, ctl, 6'b110000); end
    total++;
`else
    if (ctl !== 6'b100000) begin bad++; $display("FAIL %s_okay got=%b want=%b", name, ctl, 6'b100000); end
    total++;
`endif
    if (clint_hrdata !== 32'h0) begin bad++; $display("FAIL %s_data got=%h want=%h", name, clint_hrdata, 32'h0); end
    total++;
    addr_phase(1'b0, 16'h4000, 3'b010, 2'b11);
    tick(); idle_bus(); #1;
    $display("txn follow-up read 0x4000 ctl=%b hrdata=%h", ctl, clint_hrdata);
    if (ctl !== 6'b100000 || clint_hrdata !== 32'h1111_1111) begin
      bad++; $display("FAIL %s_next got=%b/%h want=%b/%h", name, ctl, clint_hrdata, 6'b100000, 32'h1111_1111);
    end
    total++;
  endtask

  task test_write_user_mode();
    illegal_txn("umode_wr", 1'b1, 16'h0000, 3'b010, 2'b00);
  endtask

  task test_illegal();
    illegal_txn("unaligned", 1'b0, 16'h4002, 3'b010, 2'b11);
    illegal_txn("unmapped",  1'b0, 16'h8000, 3'b010, 2'b11);
    illegal_txn("byte_rd",   1'b0, 16'h0000, 3'b000, 2'b11);
    illegal_txn("ro_wr",     1'b1, 16'hBFFC, 3'b010, 2'b11);
  endtask

  task test_reset_mid();
`ifdef CLINT_ERR_RESP_EN
    addr_phase(1'b1, 16'h0000, 3'b010, 2'b00);
    tick(); idle_bus(); #1;
    if (ctl !== 6'b010000) begin bad++; $display("FAIL rstmid_err1 got=%b want=%b", ctl, 6'b010000); end
    total++;
`else
    addr_phase(1'b1, 16'h0000, 3'b010, 2'b11);
    tick(); idle_bus(); clint_hwdata = 32'h1; #1;
    if (ctl !== 6'b101001) begin bad++; $display("FAIL rstmid_data got=%b want=%b", ctl, 6'b101001); end
    total++;
`endif
    cpurst_b = 1'b0;
    #1;
    $display("txn async reset mid-transfer ctl=%b", ctl);
    if (ctl !== 6'b100000) begin bad++; $display("FAIL rstmid_abort got=%b want=%b", ctl, 6'b100000); end
    total++;
    tick();
    cpurst_b = 1'b1;
    addr_phase(1'b0, 16'h4004, 3'b010, 2'b11);
    tick(); idle_bus(); #1;
    $display("txn read 0x4004 after reset ctl=%b hrdata=%h", ctl, clint_hrdata);
    if (ctl !== 6'b100000 || clint_hrdata !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL rstmid_read got=%b/%h want=%b/%h", ctl, clint_hrdata, 6'b100000, 32'hFFFF_FFFF);
    end
    total++;
  endtask

  initial begin
    msip_value        = 32'h0000_00A5;
    mtimecmp_lo_value = 32'h1111_1111;
    mtimecmp_hi_value = 32'h2222_2222;
    mtime_lo_value    = 32'h0000_1234;
    mtime_hi_value    = 32'hDEAD_BEEF;
    test_reset();
    test_idle_htrans();
    test_write_msip();
    test_read_cmp_hi();
    test_back_to_back();
    test_write_user_mode();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pa_clint_busif.md
Name: pa_clint_busif

Overview:
- AHB-Lite slave front end of the CLINT; sits directly upstream of the CLINT register block.
- Decodes bus address phases into per-register select strobes and a data-phase write strobe, and muxes register values onto hrdata.
- Generates OKAY/ERROR responses, including the two-cycle ERROR sequence.
- Register storage and interrupt generation stay in the register block; this block holds only bus pipeline state.

Parameters:
- ADDR_W, 16, width of the CLINT offset address.

Ports:
- clint_clk  input  1  CLINT clock.
- cpurst_b  input  1  reset, asynchronous, active-low.
- clint_hsel  input  1  slave select.
- clint_htrans  input  2  AHB transfer type; only NONSEQ (2'b10) and SEQ (2'b11) start a transfer.
- clint_hwrite  input  1  1 = write.
- clint_haddr  input  ADDR_W  byte offset.
- clint_hsize  input  3  transfer size.
- clint_hwdata  input  32  write data, valid in the data phase.
- clint_hready  output  1  transfer-done / slave ready.
- clint_hresp  output  1  0 = OKAY, 1 = ERROR.
- clint_hrdata  output  32  read data.
- cpu_clint_mode  input  2  CPU privilege mode, sampled in the address phase.
- busif_regs_msip_sel  output  1  data-phase select for MSIP.
- busif_regs_mtimecmp_lo_sel  output  1  data-phase select for MTIMECMP_LO.
- busif_regs_mtimecmp_hi_sel  output  1  data-phase select for MTIMECMP_HI.
- busif_regs_wdata  output  32  equals clint_hwdata.
- busif_regs_write_vld  output  1  legal write in its OKAY data phase.
- msip_value  input  32  MSIP register value.
- mtimecmp_lo_value  input  32  MTIMECMP_LO register value.
- mtimecmp_hi_value  input  32  MTIMECMP_HI register value.
- mtime_lo_value  input  32  MTIME low word.
- mtime_hi_value  input  32  MTIME high word.

Behaviour:
- Address map:
  - 0x0000 MSIP (RW)
  - 0x4000 MTIMECMP_LO (RW)
  - 0x4004 MTIMECMP_HI (RW)
  - 0xBFF8 MTIME_LO (RO)
  - 0xBFFC MTIME_HI (RO)
  - Any other offset is unmapped.
- Address-phase accept: clint_hsel & clint_htrans[1] & clint_hready. On accept, register into the data-phase state: write flag, decoded one-hot select, and an illegal flag.
- Illegal conditions (any one is sufficient):
  - clint_hsize != 3'b010
  - clint_haddr[1:0] != 0
  - unmapped offset
  - write to MTIME_LO or MTIME_HI
  - write with cpu_clint_mode != 2'b11
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE: no data phase pending. Accept to DATA if legal, to ERR1 if illegal.
  - DATA: one cycle. hready=1, hresp=0.
    - If write: busif_regs_write_vld=1 and the matching select is high; the register updates at the end of this cycle.
    - If read: hrdata = selected value, combinational from the registered select.
    - A new accept in this cycle goes to DATA or ERR1; otherwise the FSM goes to IDLE.
  - ERR1: hready=0, hresp=1. Always goes to ERR2.
  - ERR2: hready=1, hresp=1. Accepting a new address phase here is allowed and is handled as from IDLE.
- Selects and write_vld are forced to 0 outside DATA. During DATA they are 0 unless the transfer is a legal write.
- hrdata is 0 except during a legal read DATA cycle.
- Zero wait states: OKAY latency is 1 data cycle; ERROR latency is 2 cycles.
- Back-to-back transfers run at full throughput.
- Reset values: state IDLE, clint_hready=1, clint_hresp=0, clint_hrdata=0, all selects 0, busif_regs_write_vld=0.
- An asynchronous reset mid-transfer aborts the transfer with no register write.
- IDLE/BUSY htrans, or hsel=0, while hready=1 leaves the FSM in IDLE.

Optional Feature:
- Macro: CLINT_ERR_RESP_EN.
- Defined: illegal transfers take the ERR1/ERR2 sequence described above.
- Undefined:
  - ERR1/ERR2 are never entered.
  - Illegal transfers complete in a single OKAY DATA cycle with hrdata=0 and no write strobe.
  - clint_hresp is tied to 0.

Test Plan:
1. Write 0x1 to 0x0000 in M mode (2'b11) -> next cycle busif_regs_msip_sel=1, write_vld=1, wdata=0x1, hready=1, hresp=0.
2. Read 0x4004 with mtimecmp_hi_value=0xFFFFFFFF -> data-phase hrdata=0xFFFFFFFF, OKAY, all selects 0.
3. Back-to-back: write 0x4000=0x10, read 0xBFF8 (mtime_lo_value=0x1234), write 0x4004=0x0 -> three consecutive DATA cycles with no wait states; read returns 0x1234; only the two writes assert write_vld.
4. Write 0x0000 with mode=2'b00 -> write_vld stays 0; with CLINT_ERR_RESP_EN, hready/hresp = 0/1 then 1/1; without it, one OKAY cycle.
5. Illegal accesses to 0x4002 (unaligned), 0x8000 (unmapped), a hsize=3'b000 read, and a write to 0xBFFC -> each gives a two-cycle ERROR, no write_vld, hrdata=0.
6. Assert cpurst_b low during ERR1 -> hready=1, hresp=0, state IDLE immediately; a following legal read completes normally.
